// File: rtl/calc_key_sequencer.sv
// Keypad calculator sequencer: turns accepted key codes into one-cycle datapath pulses.
// Optional overflow lock-out is enabled by defining CALC_OVF_LOCK_EN.
module calc_key_sequencer #(
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [3:0] digit,
  output logic       a_clr,
  output logic       a_shift,
  output logic       a_ld_alu,
  output logic       a_ld_mem,
  output logic       b_clr,
  output logic       b_shift,
  output logic       b_ld_mem,
  output logic       m_ld,
  output logic       alu_sub,
  output logic       disp_sel,
  output logic [1:0] phase,
  input  logic       alu_ovf
);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'b000,
    S_OP      = 3'b001,
    S_ENTER_B = 3'b011,
    S_RESULT  = 3'b010,
`ifdef CALC_OVF_LOCK_EN
    S_ERR     = 3'b110,
`endif
    S_EXEC    = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  localparam logic [3:0] K_CLR = 4'hA;
  localparam logic [3:0] K_ADD = 4'hB;
  localparam logic [3:0] K_SUB = 4'hC;
  localparam logic [3:0] K_EQ  = 4'hD;
  localparam logic [3:0] K_GETM = 4'hE;
  localparam logic [3:0] K_SETM = 4'hF;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alu_sub_q, alu_sub_d;
  logic             pend_sub_q, pend_sub_d;
  logic             exec_op_q, exec_op_d;
  logic [3:0]       digit_q, digit_d;
  logic             a_clr_q, a_clr_d, a_shift_q, a_shift_d;
  logic             a_ld_alu_q, a_ld_alu_d, a_ld_mem_q, a_ld_mem_d;
  logic             b_clr_q, b_clr_d, b_shift_q, b_shift_d, b_ld_mem_q, b_ld_mem_d;
  logic             m_ld_q, m_ld_d;
  logic             disp_sel_q, disp_sel_d;
  logic [1:0]       phase_q, phase_d;
  logic             key_ready_q, key_ready_d;

  logic accept, is_digit, is_op, key_sub, can_shift;

  assign accept    = key_valid & key_ready_q;
  assign is_digit  = (key <= 4'd9);
  assign is_op     = (key == K_ADD) || (key == K_SUB);
  assign key_sub   = (key == K_SUB);
  assign can_shift = (cnt_q < CNT_MAX);

`ifndef CALC_OVF_LOCK_EN
  logic unused_alu_ovf;
  assign unused_alu_ovf = alu_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ENTER_A;
      cnt_q       <= '0;
      alu_sub_q   <= 1'b0;
      pend_sub_q  <= 1'b0;
      exec_op_q   <= 1'b0;
      digit_q     <= 4'd0;
      a_clr_q     <= 1'b0;
      a_shift_q   <= 1'b0;
      a_ld_alu_q  <= 1'b0;
      a_ld_mem_q  <= 1'b0;
      b_clr_q     <= 1'b0;
      b_shift_q   <= 1'b0;
      b_ld_mem_q  <= 1'b0;
      m_ld_q      <= 1'b0;
      disp_sel_q  <= 1'b0;
      phase_q     <= 2'b00;
      key_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_sub_q   <= alu_sub_d;
      pend_sub_q  <= pend_sub_d;
      exec_op_q   <= exec_op_d;
      digit_q     <= digit_d;
      a_clr_q     <= a_clr_d;
      a_shift_q   <= a_shift_d;
      a_ld_alu_q  <= a_ld_alu_d;
      a_ld_mem_q  <= a_ld_mem_d;
      b_clr_q     <= b_clr_d;
      b_shift_q   <= b_shift_d;
      b_ld_mem_q  <= b_ld_mem_d;
      m_ld_q      <= m_ld_d;
      disp_sel_q  <= disp_sel_d;
      phase_q     <= phase_d;
      key_ready_q <= key_ready_d;
    end
  end

  // Next state: pend_sub/exec_op remember what to do once the EXEC cycle completes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_sub_d  = alu_sub_q;
    pend_sub_d = pend_sub_q;
    exec_op_d  = exec_op_q;
    if (state_q == S_EXEC) begin
`ifdef CALC_OVF_LOCK_EN
      if (alu_ovf) begin
        state_d = S_ERR;
      end else begin
        state_d = exec_op_q ? S_OP : S_RESULT;
      end
`else
      state_d = exec_op_q ? S_OP : S_RESULT;
`endif
      alu_sub_d = pend_sub_q;
      cnt_d     = '0;
    end else if (accept) begin
      if (key == K_CLR) begin
        state_d   = S_ENTER_A;
        cnt_d     = '0;
        alu_sub_d = 1'b0;
      end else begin
        case (state_q)
          S_ENTER_A: begin
            if (is_digit && can_shift) cnt_d = cnt_q + CNT_W'(1);
            else if (is_op) begin
              alu_sub_d = key_sub;
              state_d   = S_OP;
              cnt_d     = '0;
            end else if (key == K_GETM) cnt_d = CNT_MAX;
          end
          S_OP: begin
            if (is_digit) begin
              state_d = S_ENTER_B;
              cnt_d   = CNT_W'(1);
            end else if (is_op) alu_sub_d = key_sub;
            else if (key == K_GETM) begin
              state_d = S_ENTER_B;
              cnt_d   = CNT_MAX;
            end
          end
          S_ENTER_B: begin
            if (is_digit && can_shift) cnt_d = cnt_q + CNT_W'(1);
            else if (key == K_EQ) begin
              state_d    = S_EXEC;
              pend_sub_d = alu_sub_q;
              exec_op_d  = 1'b0;
            end else if (is_op) begin
              state_d    = S_EXEC;
              pend_sub_d = key_sub;
              exec_op_d  = 1'b1;
            end else if (key == K_GETM) cnt_d = CNT_MAX;
          end
          S_RESULT: begin
            if (is_digit) begin
              state_d = S_ENTER_A;
              cnt_d   = CNT_W'(1);
            end else if (is_op) begin
              alu_sub_d = key_sub;
              state_d   = S_OP;
              cnt_d     = '0;
            end else if (key == K_GETM) begin
              state_d = S_ENTER_A;
              cnt_d   = CNT_MAX;
            end else if (key == K_EQ) begin
              state_d    = S_EXEC;
              pend_sub_d = alu_sub_q;
              exec_op_d  = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs: every pulse is registered, so it appears the cycle after the key is accepted.
  always_comb begin
    digit_d    = digit_q;
    disp_sel_d = disp_sel_q;
    a_clr_d    = 1'b0;
    a_shift_d  = 1'b0;
    a_ld_mem_d = 1'b0;
    b_clr_d    = 1'b0;
    b_shift_d  = 1'b0;
    b_ld_mem_d = 1'b0;
    m_ld_d     = 1'b0;
    if (state_q == S_EXEC) begin
      disp_sel_d = 1'b0;
    end else if (accept) begin
      if (key == K_CLR) begin
        a_clr_d    = 1'b1;
        b_clr_d    = 1'b1;
        disp_sel_d = 1'b0;
      end else begin
        case (state_q)
          S_ENTER_A: begin
            if (is_digit && can_shift) begin
              a_clr_d   = (cnt_q == '0);
              a_shift_d = 1'b1;
              digit_d   = key;
            end else if (key == K_GETM) a_ld_mem_d = 1'b1;
            else if (key == K_SETM) m_ld_d = 1'b1;
          end
          S_OP: begin
            if (is_digit) begin
              b_clr_d    = 1'b1;
              b_shift_d  = 1'b1;
              digit_d    = key;
              disp_sel_d = 1'b1;
            end else if (key == K_GETM) begin
              b_ld_mem_d = 1'b1;
              disp_sel_d = 1'b1;
            end
          end
          S_ENTER_B: begin
            if (is_digit && can_shift) begin
              b_shift_d = 1'b1;
              digit_d   = key;
            end else if (key == K_GETM) b_ld_mem_d = 1'b1;
          end
          S_RESULT: begin
            if (is_digit) begin
              a_clr_d   = 1'b1;
              a_shift_d = 1'b1;
              digit_d   = key;
            end else if (key == K_SETM) m_ld_d = 1'b1;
            else if (key == K_GETM) a_ld_mem_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
    a_ld_alu_d  = (state_d == S_EXEC);
    key_ready_d = (state_d != S_EXEC);
    case (state_d)
      S_ENTER_A: phase_d = 2'b00;
      S_OP:      phase_d = 2'b01;
      S_ENTER_B: phase_d = 2'b11;
      S_RESULT:  phase_d = 2'b10;
`ifdef CALC_OVF_LOCK_EN
      S_ERR:     phase_d = 2'b10;
`endif
      default:   phase_d = phase_q;
    endcase
  end

  assign key_ready = key_ready_q;
  assign digit     = digit_q;
  assign a_clr     = a_clr_q;
  assign a_shift   = a_shift_q;
  assign a_ld_alu  = a_ld_alu_q;
  assign a_ld_mem  = a_ld_mem_q;
  assign b_clr     = b_clr_q;
  assign b_shift   = b_shift_q;
  assign b_ld_mem  = b_ld_mem_q;
  assign m_ld      = m_ld_q;
  assign alu_sub   = alu_sub_q;
  assign disp_sel  = disp_sel_q;
  assign phase     = phase_q;

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Synchronous controller for the keypad calculator datapath: operand register A, operand register B, memory register M and the add/sub ALU.
- Consumes one decoded keypad code per accepted strobe and issues registered one-cycle load/shift/clear pulses to the datapath.
- Reports the 2-bit entry phase (00 enter A, 01 operator pending, 11 enter B, 10 result shown) that drives the display/select decoders.
- Sits between the keypad scanner and the register file/ALU.

Parameters:
MAX_DIGITS, 4, max digits accepted per operand; further digits ignored
CNT_W, 3, width of internal digit counter; must hold MAX_DIGITS

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
key  in  4  key code: 0-9 digit, A clear, B add, C sub, D equals, E getM (#), F setM (*)
key_valid  in  1  one-cycle strobe; key sampled when key_valid & key_ready
key_ready  out  1  1 = key accepted this cycle; 0 during execute cycle
digit  out  4  registered copy of last accepted digit, feeds shift-in
a_clr  out  1  pulse: A <= 0 (with a_shift: A <= digit)
a_shift  out  1  pulse: A <= A*10 + digit
a_ld_alu  out  1  pulse: A <= ALU(A,B)
a_ld_mem  out  1  pulse: A <= M
b_clr  out  1  pulse: B <= 0 (with b_shift: B <= digit)
b_shift  out  1  pulse: B <= B*10 + digit
b_ld_mem  out  1  pulse: B <= M
m_ld  out  1  pulse: M <= A
alu_sub  out  1  latched operator: 0 add, 1 sub; stable while a_ld_alu
disp_sel  out  1  0 show A, 1 show B
phase  out  2  entry phase code
alu_ovf  in  1  ALU overflow flag, valid with a_ld_alu (used only with the optional feature)

Behaviour:
- Reset (async, immediate): phase=00, internal state ENTER_A, digit count 0, alu_sub=0, disp_sel=0, digit=0, key_ready=1, all pulses 0. M contents are not touched by this block.
- Latency: key accepted at edge N; pulses valid in cycle N+1, exactly one cycle wide. All outputs are registered.
- key_valid while key_ready=0 is dropped, not queued.
- Internal states: ENTER_A(00), OP(01), ENTER_B(11), RESULT(10), EXEC (transient, phase holds the previous code).
- ENTER_A behaviour:
  - digit: first digit (cnt=0) gives a_clr+a_shift; later digits give a_shift; cnt++.
  - digit when cnt==MAX_DIGITS: ignored.
  - B/C: latch alu_sub, go OP, cnt=0.
  - E: a_ld_mem, cnt=MAX_DIGITS, so following digits are ignored.
  - F: m_ld.
  - D: no-op.
- OP behaviour:
  - digit: b_clr+b_shift, cnt=1, disp_sel=1, go ENTER_B.
  - B/C: overwrite alu_sub.
  - E: b_ld_mem, disp_sel=1, cnt=MAX_DIGITS, go ENTER_B.
  - D/F: no-op.
- ENTER_B behaviour:
  - digit: b_shift, with the same cnt limit.
  - D: go EXEC, then RESULT.
  - B/C: go EXEC, then OP with the new operator (chained operation).
  - E: b_ld_mem.
  - F: no-op.
- EXEC (one cycle): a_ld_alu=1 using the previous alu_sub; key_ready=0; disp_sel<=0.
  - For chaining, the new alu_sub takes effect in the cycle after EXEC.
- RESULT behaviour:
  - digit: a_clr+a_shift, cnt=1, go ENTER_A.
  - B/C: latch op, go OP.
  - F: m_ld.
  - E: a_ld_mem, go ENTER_A.
  - D: re-execute with the same B (go EXEC, then RESULT).
- Key A (clear), from any state: a_clr, b_clr, cnt=0, alu_sub=0, disp_sel=0, go ENTER_A. M is kept.
- cnt saturates at MAX_DIGITS and never wraps.
- rst asserted mid-EXEC aborts: a_ld_alu is forced to 0 immediately.

Optional Feature:
- Macro: CALC_OVF_LOCK_EN.
- Defined: if alu_ovf=1 during the EXEC cycle, enter ERR state (phase=10, disp_sel=0). In ERR all keys except A are ignored; A clears as normal.
- Undefined: alu_ovf is ignored and the ERR state does not exist.

Test Plan:
- Reset, then keys 1,2 -> cycle after 1: a_clr=a_shift=1, digit=1. After 2: a_shift=1 only, digit=2. phase=00.
- Keys 5,B,3,D -> B gives phase 01, alu_sub=0. 3 gives b_clr+b_shift, disp_sel=1, phase 11. D gives one-cycle a_ld_alu, key_ready=0, then phase 10, disp_sel=0.
- MAX_DIGITS=4, keys 1,2,3,4,5 -> fifth key produces no pulses, digit stays 4.
- Keys 9,C,2,B -> EXEC with alu_sub=1, then phase 01 with alu_sub=0. key_valid pulsed during EXEC is dropped.
- Keys 7,F,A,E -> m_ld, then a_clr+b_clr, then a_ld_mem, phase 00. A following digit is ignored (cnt saturated).
- Assert rst during the EXEC cycle -> all pulses 0 immediately, phase=00, key_ready=1. With CALC_OVF_LOCK_EN, alu_ovf=1 at EXEC -> digits ignored until key A.
